// File: rtl/pool_pkg.sv
// Shared constants for the 2x2 pooling window buffer: default pixel width,
// pixels per window and the slot order of the packed window word.
package pool_pkg;
    localparam int DATA_W_DEF = 32;
    localparam int WIN_PIXELS = 4;
    localparam int SLOT_TL    = 0;
    localparam int SLOT_TR    = 1;
    localparam int SLOT_BL    = 2;
    localparam int SLOT_BR    = 3;
endpackage

// File: rtl/pool_window_buffer_if.sv
// Pixel-in / window-out handshake bundle for pool_window_buffer.
// Optional win_last signal is present only when POOL_WIN_LAST_EN is defined.
interface pool_window_buffer_if #(
    parameter int DATA_W = pool_pkg::DATA_W_DEF
);
    logic                                   valid_in;
    logic                                   in_ready;
    logic [DATA_W-1:0]                      input_data;
    logic                                   valid_out;
    logic                                   out_ready;
    logic [pool_pkg::WIN_PIXELS*DATA_W-1:0] win_data;
`ifdef POOL_WIN_LAST_EN
    logic                                   win_last;
`endif

    modport slave (
        input  valid_in, input_data, out_ready,
`ifdef POOL_WIN_LAST_EN
        output win_last,
`endif
        output in_ready, valid_out, win_data
    );

    modport master (
        output valid_in, input_data, out_ready,
`ifdef POOL_WIN_LAST_EN
        input  win_last,
`endif
        input  in_ready, valid_out, win_data
    );
endinterface

// File: rtl/pool_line_ram.sv
// Single-port line buffer: combinational read, synchronous write, one address.
module pool_line_ram #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16,
    parameter int AW     = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);
    logic [DATA_W-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_addr];
endmodule

// File: rtl/pool_window_buffer.sv
// Streams a raster frame in and emits non-overlapping 2x2 windows {BR,BL,TR,TL}.
// Defining POOL_WIN_LAST_EN adds a win_last flag on the final window of a frame.
module pool_window_buffer
    import pool_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int IMG_W  = 16,
    parameter int IMG_H  = 16
) (
    input logic                 clk,
    input logic                 rst_n,
    pool_window_buffer_if.slave bus
);
    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    if ((IMG_W % 2) != 0 || IMG_W < 2) begin : g_bad_img_w
        $error("pool_window_buffer: IMG_W must be even and at least 2");
    end
    if ((IMG_H % 2) != 0 || IMG_H < 2) begin : g_bad_img_h
        $error("pool_window_buffer: IMG_H must be even and at least 2");
    end

    logic [CW-1:0]                 r_col;
    logic [RW-1:0]                 r_row;
    logic [DATA_W-1:0]             r_bl;
    logic [DATA_W-1:0]             r_tl;
    logic [WIN_PIXELS*DATA_W-1:0]  r_win;
    logic                          r_valid;
    logic                          r_last;

    logic                          w_inReady;
    logic                          w_accept;
    logic                          w_we;
    logic                          w_load;
    logic                          w_colEnd;
    logic                          w_rowEnd;
    logic [DATA_W-1:0]             w_rd;
    logic [WIN_PIXELS*DATA_W-1:0]  w_win;

    assign w_inReady = !r_valid || bus.out_ready;
    assign w_accept  = bus.valid_in && w_inReady;
    assign w_colEnd  = (r_col == CW'(IMG_W - 1));
    assign w_rowEnd  = (r_row == RW'(IMG_H - 1));
    assign w_we      = w_accept && !r_row[0];
    assign w_load    = w_accept && r_row[0] && r_col[0];

    pool_line_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (IMG_W),
        .AW     (CW)
    ) u_line (
        .clk     (clk),
        .i_we    (w_we),
        .i_addr  (r_col),
        .i_wdata (bus.input_data),
        .o_rdata (w_rd)
    );

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_col <= '0;
            r_row <= '0;
        end else if (w_accept) begin
            if (w_colEnd) begin
                r_col <= '0;
                r_row <= w_rowEnd ? '0 : r_row + RW'(1);
            end else begin
                r_col <= r_col + CW'(1);
            end
        end
    end

    // The single RAM port only reads line[col]; TL is grabbed on the even column
    // so that TR can be read directly on the odd column when the window closes.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_bl <= '0;
            r_tl <= '0;
        end else if (w_accept && r_row[0] && !r_col[0]) begin
            r_bl <= bus.input_data;
            r_tl <= w_rd;
        end
    end

    always_comb begin
        w_win = '0;
        w_win[SLOT_TL*DATA_W +: DATA_W] = r_tl;
        w_win[SLOT_TR*DATA_W +: DATA_W] = w_rd;
        w_win[SLOT_BL*DATA_W +: DATA_W] = r_bl;
        w_win[SLOT_BR*DATA_W +: DATA_W] = bus.input_data;
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_valid <= 1'b0;
            r_win   <= '0;
            r_last  <= 1'b0;
        end else if (w_load) begin
            r_valid <= 1'b1;
            r_win   <= w_win;
            r_last  <= w_rowEnd && w_colEnd;
        end else if (bus.out_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign bus.in_ready  = w_inReady;
    assign bus.valid_out = r_valid;
    assign bus.win_data  = r_win;
`ifdef POOL_WIN_LAST_EN
    assign bus.win_last  = r_last;
`else
    logic w_unusedLast;
    assign w_unusedLast = r_last;
`endif
endmodule

// File: tb/tb_pool_window_buffer.sv
// Directed bench for pool_window_buffer: 4x4 frames with hand-computed windows,
// plus a randomized-gap 16x16 frame checked against a frame-array model.
module tb_pool_window_buffer;
    import pool_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n;
    int           tests = 0;
    int           fails = 0;
    logic         accA;
    int           xferA;

    pool_window_buffer_if #(.DATA_W(32)) busA ();
    pool_window_buffer_if #(.DATA_W(32)) busB ();

    pool_window_buffer #(.DATA_W(32), .IMG_W(4), .IMG_H(4)) dutA (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (busA)
    );

    pool_window_buffer #(.DATA_W(32), .IMG_W(16), .IMG_H(16)) dutB (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (busB)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] expWin4(input int tl);
        return {32'(tl + 5), 32'(tl + 4), 32'(tl + 1), 32'(tl)};
    endfunction

    task automatic checkOutput(input string tag, input logic [127:0] observed, input logic [127:0] expected);
        tests++;
        assert (observed === expected) else begin
            fails++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // One clock of the 4x4 instance; records acceptance and window transfers.
    task automatic applyStimulus(input logic vin, input int data, input logic ordy);
        busA.valid_in   = vin;
        busA.input_data = 32'(data);
        busA.out_ready  = ordy;
        #1;
        accA = vin && busA.in_ready;
        if (busA.valid_out && ordy) xferA++;
        @(posedge clk);
        #1;
    endtask

    logic [31:0]  frameB [256];
    logic [127:0] expB   [64];
    int           idx, wcnt, cyc, p;
    logic         vin, ordy;

    initial begin
        busB.valid_in = 1'b0; busB.input_data = '0; busB.out_ready = 1'b0;
        xferA = 0;
        rst_n = 1'b1;
        applyStimulus(0, 0, 0);
        applyStimulus(0, 0, 0);
        checkOutput("rst_valid", 128'(busA.valid_out), 128'(0));
        checkOutput("rst_win", busA.win_data, 128'(0));
        rst_n = 1'b0;
        applyStimulus(0, 0, 0);
        checkOutput("rst_in_ready", 128'(busA.in_ready), 128'(1));

        // 4x4 frame 0..15, always ready
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1, i, 1);
            if (i == 5 || i == 7 || i == 13 || i == 15) begin
                checkOutput("t1_valid", 128'(busA.valid_out), 128'(1));
                checkOutput("t1_win", busA.win_data, expWin4(i - 5));
`ifdef POOL_WIN_LAST_EN
                checkOutput("t1_last", 128'(busA.win_last), 128'(i == 15));
`endif
            end else if (i < 5 || i == 6 || i == 8 || i == 14) begin
                checkOutput("t1_idle", 128'(busA.valid_out), 128'(0));
            end
        end
        applyStimulus(0, 0, 1);
        checkOutput("t1_drain", 128'(busA.valid_out), 128'(0));

        // Backpressure from the first window onward
        for (int i = 0; i < 6; i++) applyStimulus(1, i, 1);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1, 6, 0);
            checkOutput("t2_no_accept", 128'(accA), 128'(0));
            checkOutput("t2_hold_valid", 128'(busA.valid_out), 128'(1));
            checkOutput("t2_hold_win", busA.win_data, expWin4(0));
            checkOutput("t2_in_ready", 128'(busA.in_ready), 128'(0));
        end
        for (int i = 6; i < 16; i++) begin
            applyStimulus(1, i, 1);
            if (i == 7 || i == 13 || i == 15) begin
                checkOutput("t2_valid", 128'(busA.valid_out), 128'(1));
                checkOutput("t2_win", busA.win_data, expWin4(i - 5));
            end
        end
        applyStimulus(0, 0, 1);

        // Reset after pixel 6, then a fresh frame 100..115
        for (int i = 0; i < 7; i++) applyStimulus(1, i, 1);
        rst_n = 1'b1;
        applyStimulus(0, 0, 1);
        rst_n = 1'b0;
        checkOutput("t3_rst_valid", 128'(busA.valid_out), 128'(0));
        checkOutput("t3_rst_win", busA.win_data, 128'(0));
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1, 100 + i, 1);
            if (i == 5 || i == 7 || i == 13 || i == 15) begin
                checkOutput("t3_win", busA.win_data, expWin4(100 + i - 5));
            end else if (i < 5) begin
                checkOutput("t3_idle", 128'(busA.valid_out), 128'(0));
            end
        end
        applyStimulus(0, 0, 1);

        // Two back-to-back frames 200..231
        xferA = 0;
        for (int i = 0; i < 32; i++) begin
            p = i % 16;
            applyStimulus(1, 200 + i, 1);
            if (p == 5 || p == 7 || p == 13 || p == 15) begin
                checkOutput("t4_valid", 128'(busA.valid_out), 128'(1));
                checkOutput("t4_win", busA.win_data, expWin4(200 + i - 5));
            end else if (p < 5) begin
                checkOutput("t4_idle", 128'(busA.valid_out), 128'(0));
            end
        end
        applyStimulus(0, 0, 1);
        checkOutput("t4_count", 128'(xferA), 128'(8));

        // 16x16 frame with random gaps on both sides
        for (int i = 0; i < 256; i++) frameB[i] = $urandom;
        for (int r = 0; r < 8; r++) begin
            for (int c = 0; c < 8; c++) begin
                expB[r*8 + c] = {frameB[(2*r+1)*16 + 2*c + 1], frameB[(2*r+1)*16 + 2*c],
                                 frameB[(2*r)*16 + 2*c + 1],   frameB[(2*r)*16 + 2*c]};
            end
        end
        idx = 0; wcnt = 0; cyc = 0;
        while ((idx < 256 || wcnt < 64) && cyc < 4000) begin
            vin  = (idx < 256) && ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 2) != 0);
            busB.valid_in   = vin;
            busB.input_data = (idx < 256) ? frameB[idx] : 32'd0;
            busB.out_ready  = ordy;
            #1;
            if (busB.valid_out && ordy) begin
                if (wcnt < 64) checkOutput("b_win", busB.win_data, expB[wcnt]);
                wcnt++;
            end
            if (vin && busB.in_ready) idx++;
            @(posedge clk);
            #1;
            cyc++;
        end
        busB.valid_in = 1'b0;
        busB.out_ready = 1'b1;
        checkOutput("b_count", 128'(wcnt), 128'(64));
        checkOutput("b_pixels", 128'(idx), 128'(256));
        @(posedge clk);
        #1;
        checkOutput("b_drained", 128'(busB.valid_out), 128'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
